// File: rtl/led_scan_driver_if.sv
// Bundle between the scan driver and the display digit sources.
//   num        : 4-bit digit value returned by the source whose en bit is low
//   digit_mask : 1 = digit enabled (slot kept, en stays high when 0)
//   lz_en      : 1 = blank leading zeros
//   en         : active-low digit enables, at most one low at a time
//   seg        : active-low segments {dp,g,f,e,d,c,b,a}
//   frame_tick : one-cycle pulse on the first cycle of the top digit's slot
// master = scan driver, slave = digit sources / display side.
interface led_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic [3:0]            num;
    logic [NUM_DIGITS-1:0] digit_mask;
    logic                  lz_en;
    logic [NUM_DIGITS-1:0] en;
    logic [7:0]            seg;
    logic                  frame_tick;

    modport master (
        input  num, digit_mask, lz_en,
        output en, seg, frame_tick
    );

    modport slave (
        output num, digit_mask, lz_en,
        input  en, seg, frame_tick
    );
endinterface

// File: rtl/led_scan_driver.sv
// Multiplexed 7-segment scan controller.
// Steps through NUM_DIGITS slots of SCAN_DIV cycles each, top digit first.
// Every slot opens with BLANK_CYCLES of all-high enables, then one SETTLE
// cycle with the digit enable low, then SHOW cycles where seg holds the
// decode of num sampled at the end of SETTLE. Optional leading-zero blanking.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : led_scan_driver_if master modport (num/digit_mask/lz_en in,
//           en/seg/frame_tick out, all outputs registered)
module led_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    led_scan_driver_if.master bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_SETTLE = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_TOP    = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_SETTLE,
        ST_SHOW
    } state_e;

    state_e                state_q, state_d;
    logic                  run_q, run_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  act_q, act_d;
    logic                  lzen_q, lzen_d;
    logic                  nz_q, nz_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic [7:0]            seg_q, seg_d;
    logic                  tick_q, tick_d;
    logic [NUM_DIGITS-1:0] dig_sel;

    function automatic logic [7:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0: seg_decode = 8'hC0;
            4'h1: seg_decode = 8'hF9;
            4'h2: seg_decode = 8'hA4;
            4'h3: seg_decode = 8'hB0;
            4'h4: seg_decode = 8'h99;
            4'h5: seg_decode = 8'h92;
            4'h6: seg_decode = 8'h82;
            4'h7: seg_decode = 8'hF8;
            4'h8: seg_decode = 8'h80;
            4'h9: seg_decode = 8'h90;
            4'hA: seg_decode = 8'h88;
            4'hB: seg_decode = 8'h83;
            4'hC: seg_decode = 8'hC6;
            4'hD: seg_decode = 8'hA1;
            4'hE: seg_decode = 8'h86;
            4'hF: seg_decode = 8'h8E;
            default: seg_decode = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            run_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= IDX_TOP;
            act_q   <= 1'b0;
            lzen_q  <= 1'b0;
            nz_q    <= 1'b0;
            en_q    <= '1;
            seg_q   <= '1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            act_q   <= act_d;
            lzen_q  <= lzen_d;
            nz_q    <= nz_d;
            en_q    <= en_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
        end
    end

    // Outputs are registered from the next-state values so that en/seg/tick
    // line up with the slot position they describe. The first edge after
    // reset re-enters slot 0 of the top digit (run_q low) so that cycle
    // carries frame_tick.
    always_comb begin
        run_d = 1'b1;
        if (!run_q) begin
            cnt_d = '0;
            idx_d = IDX_TOP;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == '0) ? IDX_TOP : idx_q - 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
            idx_d = idx_q;
        end

        if (cnt_d == CNT_SETTLE) begin
            state_d = ST_SETTLE;
        end else if (cnt_d > CNT_SETTLE) begin
            state_d = ST_SHOW;
        end else begin
            state_d = ST_BLANK;
        end

        dig_sel = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d;
        tick_d  = (cnt_d == '0) && (idx_d == IDX_TOP);
        en_d    = '1;
        seg_d   = '1;
        act_d   = act_q;
        lzen_d  = lzen_q;
        nz_d    = tick_d ? 1'b0 : nz_q;

        case (state_d)
            ST_SETTLE: begin
                act_d  = bus.digit_mask[idx_d];
                lzen_d = bus.lz_en;
            end
            ST_SHOW: begin
                if (state_q == ST_SETTLE) begin
                    // Single sample point per slot; num is valid here
                    // because en was low throughout SETTLE.
                    if (act_q) begin
                        if (bus.num != 4'h0) begin
                            nz_d = 1'b1;
                        end
                        if (lzen_q && !nz_q && (bus.num == 4'h0) && (idx_q != '0)) begin
                            seg_d = '1;
                        end else begin
                            seg_d = seg_decode(bus.num);
                        end
                    end
                end else begin
                    seg_d = seg_q;
                end
            end
            default: ;
        endcase

        if ((state_d != ST_BLANK) && act_d) begin
            en_d = ~dig_sel;
        end
    end

    assign bus.en         = en_q;
    assign bus.seg        = seg_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_led_scan_driver.sv
module tb_led_scan_driver;
    localparam logic [7:0] DEC [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   onehot_errs = 0;
    int   blank_errs = 0;
    int   x_errs = 0;

    logic       src_model = 1'b0;
    logic [3:0] num_const = 4'h5;
    logic [3:0] src_val [8];

    led_scan_driver_if #(.NUM_DIGITS(8)) bus ();

    led_scan_driver #(
        .NUM_DIGITS  (8),
        .SCAN_DIV    (10),
        .BLANK_CYCLES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Digit source: constant value, or per-digit model that returns X
    // whenever no enable is low.
    always_comb begin
        if (src_model) begin
            bus.num = 4'bxxxx;
            for (int i = 0; i < 8; i++) begin
                if (!bus.en[i]) bus.num = src_val[i];
            end
        end else begin
            bus.num = num_const;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            a_onehot: assert ($countones(~bus.en) <= 1) else onehot_errs++;
            if ((&bus.en) && (bus.seg !== 8'hFF)) blank_errs++;
            if ($isunknown(bus.seg) || $isunknown(bus.en)) x_errs++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse reset, release, and stop #1 after the first edge (cycle 0).
    task automatic start_scan();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp_en, exp_seg;
        logic       exp_tick;
        int         slot, d;
        src_model = 1'b0;
        num_const = 4'h5;
        bus.digit_mask = 8'hFF;
        bus.lz_en = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.en !== 8'hFF || bus.seg !== 8'hFF || bus.frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold en=%h seg=%h tick=%b required en=ff seg=ff tick=0",
                     bus.en, bus.seg, bus.frame_tick);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c <= 80; c++) begin
            slot = c % 10;
            d = 7 - ((c / 10) % 8);
            exp_en = 8'h01 << d;
            exp_en = (slot < 2) ? 8'hFF : ~exp_en;
            exp_seg = (slot < 3) ? 8'hFF : 8'h92;
            exp_tick = (c == 0) || (c == 80);
            vectors++;
            if (bus.en !== exp_en) begin
                miscompares++;
                $display("FAIL reset_en cycle %0d got %h required %h", c, bus.en, exp_en);
            end
            vectors++;
            if (bus.seg !== exp_seg) begin
                miscompares++;
                $display("FAIL reset_seg cycle %0d got %h required %h", c, bus.seg, exp_seg);
            end
            vectors++;
            if (bus.frame_tick !== exp_tick) begin
                miscompares++;
                $display("FAIL reset_tick cycle %0d got %b required %b", c, bus.frame_tick, exp_tick);
            end
            adv(1);
        end
    endtask

    task automatic test_decode();
        logic [7:0] exp_en;
        src_model = 1'b1;
        for (int i = 0; i < 8; i++) src_val[i] = 4'(i);
        bus.digit_mask = 8'hFF;
        bus.lz_en = 1'b0;
        start_scan();
        adv(5);
        for (int i = 7; i >= 0; i--) begin
            exp_en = 8'h01 << i;
            exp_en = ~exp_en;
            vectors++;
            if (bus.en !== exp_en || bus.seg !== DEC[i]) begin
                miscompares++;
                $display("FAIL decode_digit%0d en=%h seg=%h required en=%h seg=%h",
                         i, bus.en, bus.seg, exp_en, DEC[i]);
            end
            adv(10);
        end
        // Now at cycle 85; sweep 8..F on digit 0 of the following frames.
        for (int v = 8; v < 16; v++) begin
            src_val[0] = 4'(v);
            adv(70);
            vectors++;
            if (bus.en !== 8'hFE || bus.seg !== DEC[v]) begin
                miscompares++;
                $display("FAIL decode_value%0h en=%h seg=%h required en=fe seg=%h",
                         v, bus.en, bus.seg, DEC[v]);
            end
            adv(10);
        end
    endtask

    task automatic test_leading_zero();
        logic [7:0] exp1 [8] = '{8'hFF, 8'hFF, 8'hFF, 8'h99, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        logic [7:0] exp2 [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0};
        logic [7:0] exp_en;
        src_model = 1'b1;
        for (int i = 0; i < 8; i++) src_val[i] = 4'h0;
        src_val[4] = 4'h4;
        bus.digit_mask = 8'hFF;
        bus.lz_en = 1'b1;
        start_scan();
        adv(5);
        for (int k = 0; k < 8; k++) begin
            exp_en = 8'h01 << (7 - k);
            exp_en = ~exp_en;
            vectors++;
            if (bus.en !== exp_en || bus.seg !== exp1[k]) begin
                miscompares++;
                $display("FAIL lz_digit%0d en=%h seg=%h required en=%h seg=%h",
                         7 - k, bus.en, bus.seg, exp_en, exp1[k]);
            end
            adv(10);
        end
        src_val[4] = 4'h0;
        for (int k = 0; k < 8; k++) begin
            exp_en = 8'h01 << (7 - k);
            exp_en = ~exp_en;
            vectors++;
            if (bus.en !== exp_en || bus.seg !== exp2[k]) begin
                miscompares++;
                $display("FAIL lz_allzero_digit%0d en=%h seg=%h required en=%h seg=%h",
                         7 - k, bus.en, bus.seg, exp_en, exp2[k]);
            end
            adv(10);
        end
        bus.lz_en = 1'b0;
    endtask

    task automatic test_mask();
        logic [7:0] exp_en;
        int         slot, d;
        src_model = 1'b1;
        for (int i = 0; i < 8; i++) src_val[i] = 4'(i);
        bus.digit_mask = 8'hF0;
        bus.lz_en = 1'b0;
        start_scan();
        for (int c = 0; c <= 80; c++) begin
            slot = c % 10;
            d = 7 - ((c / 10) % 8);
            vectors++;
            if (bus.frame_tick !== ((c == 0) || (c == 80))) begin
                miscompares++;
                $display("FAIL mask_tick cycle %0d got %b", c, bus.frame_tick);
            end
            if (d < 4) begin
                vectors++;
                if (bus.en !== 8'hFF || bus.seg !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL mask_off cycle %0d en=%h seg=%h required en=ff seg=ff",
                             c, bus.en, bus.seg);
                end
            end else if (slot >= 3) begin
                exp_en = 8'h01 << d;
                exp_en = ~exp_en;
                vectors++;
                if (bus.en !== exp_en || bus.seg !== DEC[d]) begin
                    miscompares++;
                    $display("FAIL mask_on cycle %0d en=%h seg=%h required en=%h seg=%h",
                             c, bus.en, bus.seg, exp_en, DEC[d]);
                end
            end
            adv(1);
        end
        bus.digit_mask = 8'hFF;
    endtask

    task automatic test_num_toggle();
        src_model = 1'b1;
        for (int i = 0; i < 8; i++) src_val[i] = 4'(i);
        src_val[7] = 4'h3;
        bus.digit_mask = 8'hFF;
        bus.lz_en = 1'b0;
        start_scan();
        adv(3);
        for (int c = 3; c < 10; c++) begin
            vectors++;
            if (bus.en !== 8'h7F || bus.seg !== 8'hB0) begin
                miscompares++;
                $display("FAIL toggle_hold cycle %0d en=%h seg=%h required en=7f seg=b0",
                         c, bus.en, bus.seg);
            end
            src_val[7] = 4'(c + 5);
            adv(1);
        end
        for (int c = 10; c < 12; c++) begin
            vectors++;
            if (bus.en !== 8'hFF || bus.seg !== 8'hFF) begin
                miscompares++;
                $display("FAIL toggle_blank cycle %0d en=%h seg=%h required en=ff seg=ff",
                         c, bus.en, bus.seg);
            end
            adv(1);
        end
    endtask

    task automatic test_reset_mid_slot();
        src_model = 1'b0;
        num_const = 4'h5;
        bus.digit_mask = 8'hFF;
        bus.lz_en = 1'b0;
        start_scan();
        adv(25);
        vectors++;
        if (bus.en !== 8'hDF || bus.seg !== 8'h92) begin
            miscompares++;
            $display("FAIL midrst_pre en=%h seg=%h required en=df seg=92", bus.en, bus.seg);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.en !== 8'hFF || bus.seg !== 8'hFF || bus.frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_async en=%h seg=%h tick=%b required en=ff seg=ff tick=0",
                     bus.en, bus.seg, bus.frame_tick);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.frame_tick !== 1'b1 || bus.en !== 8'hFF) begin
            miscompares++;
            $display("FAIL midrst_restart tick=%b en=%h required tick=1 en=ff",
                     bus.frame_tick, bus.en);
        end
        adv(2);
        vectors++;
        if (bus.en !== 8'h7F || bus.seg !== 8'hFF) begin
            miscompares++;
            $display("FAIL midrst_settle en=%h seg=%h required en=7f seg=ff", bus.en, bus.seg);
        end
        adv(1);
        vectors++;
        if (bus.seg !== 8'h92) begin
            miscompares++;
            $display("FAIL midrst_show seg=%h required 92", bus.seg);
        end
    endtask

    task automatic test_invariants();
        vectors++;
        if (onehot_errs !== 0) begin
            miscompares++;
            $display("FAIL onehot_en cycles_with_multiple_low=%0d required 0", onehot_errs);
        end
        vectors++;
        if (blank_errs !== 0) begin
            miscompares++;
            $display("FAIL blank_seg cycles_with_lit_seg=%0d required 0", blank_errs);
        end
        vectors++;
        if (x_errs !== 0) begin
            miscompares++;
            $display("FAIL unknown_out cycles_with_x=%0d required 0", x_errs);
        end
    endtask

    initial begin
        bus.digit_mask = 8'hFF;
        bus.lz_en = 1'b0;
        for (int i = 0; i < 8; i++) src_val[i] = 4'h0;
        test_reset();
        test_decode();
        test_leading_zero();
        test_mask();
        test_num_toggle();
        test_reset_mid_slot();
        test_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
